ieee754_to_fixed: RTL and testbench

IEEE754_TO_FIXED -- requirements
Module: ieee754_to_fixed

---
 rtl/ieee754_to_fixed.sv | 149 ++++++++++++++
 tb/tb_ieee754_to_fixed.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_to_fixed.sv
// IEEE-754 single to signed Q16.16 (round toward zero). Latency counts the accepting edge: out_valid is high n+2 edges in, n = shift distance (0..24).
// Single operand in flight: in_ready only in IDLE; the result holds in DONE until out_ready.
module ieee754_to_fixed (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_op;
  logic [31:0] r_mag;
  logic [31:0] r_data;
  logic [3:0]  r_flags;
  logic [4:0]  r_cnt;
  logic        r_left;
  logic        r_sticky;
  logic        r_in_ready;
  logic        r_out_valid;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic [23:0] w_sig;
  logic        w_left;
  logic        w_shiftable;
  logic [4:0]  w_n;
  logic [31:0] w_dir_data;
  logic [3:0]  w_dir_flags;
  logic [31:0] w_mag_nxt;
  logic        w_sticky_nxt;
  logic [31:0] w_signed;

  assign w_sign      = r_op[31];
  assign w_exp       = r_op[30:23];
  assign w_man       = r_op[22:0];
  assign w_sig       = {1'b1, w_man};
  assign w_left      = (w_exp > 8'd134);
  // Exponents 110..141 (other than the d=0 case) need an iterative shift.
  assign w_shiftable = (w_exp >= 8'd110) && (w_exp <= 8'd141) && (w_exp != 8'd134);
  assign w_n         = !w_shiftable ? 5'd0 :
                       w_left ? 5'(w_exp - 8'd134) : 5'(8'd134 - w_exp);

  always_comb begin
    w_dir_data  = 32'h0000_0000;
    w_dir_flags = 4'b0000;
    if (w_exp == 8'd0) begin
      w_dir_flags = {3'b000, |w_man};
    end else if (w_exp == 8'hFF) begin
      if (w_man == 23'd0) begin
        w_dir_data  = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_dir_flags = 4'b0100;
      end else begin
        w_dir_flags = 4'b1000;
      end
    end else if (w_exp >= 8'd142) begin
      // -32768.0 is the one out-of-range exponent that is exactly representable.
      if (r_op == 32'hC700_0000) begin
        w_dir_data = 32'h8000_0000;
      end else begin
        w_dir_data  = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_dir_flags = 4'b0010;
      end
    end else if (w_exp <= 8'd109) begin
      w_dir_flags = 4'b0001;
    end else begin
      w_dir_data = w_sign ? (32'h0000_0000 - {8'h00, w_sig}) : {8'h00, w_sig};
    end
  end

  assign w_mag_nxt    = r_left ? {r_mag[30:0], 1'b0} : {1'b0, r_mag[31:1]};
  assign w_sticky_nxt = r_sticky | (~r_left & r_mag[0]);
  assign w_signed     = w_sign ? (32'h0000_0000 - w_mag_nxt) : w_mag_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 32'h0000_0000;
      r_mag       <= 32'h0000_0000;
      r_data      <= 32'h0000_0000;
      r_flags     <= 4'b0000;
      r_cnt       <= 5'd0;
      r_left      <= 1'b0;
      r_sticky    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= in_data;
            r_in_ready <= 1'b0;
            r_state    <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          r_mag    <= {8'h00, w_sig};
          r_left   <= w_left;
          r_cnt    <= w_n;
          r_sticky <= 1'b0;
          if (w_n == 5'd0) begin
            r_data      <= w_dir_data;
            r_flags     <= w_dir_flags;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_mag    <= w_mag_nxt;
          r_sticky <= w_sticky_nxt;
          r_cnt    <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_data      <= w_signed;
            r_flags     <= {3'b000, w_sticky_nxt};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign out_flags = r_flags;

endmodule

// File: tb/tb_ieee754_to_fixed.sv
// Bench for ieee754_to_fixed: directed vector table, random operands against a real-arithmetic model,
// plus backpressure and mid-operation reset sequences.
module tb_ieee754_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ieee754_to_fixed dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_d;
    logic [3:0]  exp_f;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Value*2^16 = (2^23+M) * 2^(E-134); truncate toward zero, saturate when |value| >= 2^15.
  function automatic void model(input logic [31:0] x, output logic [31:0] d,
                                output logic [3:0] f, output int lat);
    int  e;
    int  mag;
    real q;
    e   = int'(x[30:23]);
    d   = 32'h0;
    f   = 4'b0000;
    lat = 2;
    if (e == 0) begin
      if (x[22:0] != 23'd0) f = 4'b0001;
    end else if (e == 255) begin
      if (x[22:0] == 23'd0) begin
        f = 4'b0100;
        d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        f = 4'b1000;
      end
    end else begin
      q = (8388608.0 + real'(int'(x[22:0]))) * (2.0 ** (e - 134));
      if (x[31] && q == 2147483648.0) begin
        d = 32'h8000_0000;
      end else if (q >= 2147483648.0) begin
        f = 4'b0010;
        d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        mag = $rtoi(q);
        if (real'(mag) != q) f = 4'b0001;
        d = x[31] ? 32'(-mag) : 32'(mag);
        if (e >= 110 && e <= 141) lat = 2 + ((e > 134) ? (e - 134) : (134 - e));
      end
    end
  endfunction

  // Latency is counted in edges including the accepting one.
  task automatic run_op(input logic [31:0] din, output logic [31:0] d, output logic [3:0] f,
                        output int lat, output logic busy_ok);
    int guard;
    @(negedge clk);
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      in_data = $urandom;
      lat++;
    end
    d = out_data;
    f = out_flags;
    if (!out_valid) lat = -1;
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[17];
  logic [31:0] got_d, exp_d, d0;
  logic [3:0]  got_f, exp_f, f0;
  int          got_lat, exp_lat, guard;
  logic        busy_ok, stable_ok, quiet_ok;
  logic [31:0] x;

  initial begin
    vt[0]  = '{32'h40980000, 32'h0004C000, 4'b0000, 7};
    vt[1]  = '{32'hC0080000, 32'hFFFDE000, 4'b0000, 8};
    vt[2]  = '{32'h3F800001, 32'h00010000, 4'b0001, 9};
    vt[3]  = '{32'h33800000, 32'h00000000, 4'b0001, 2};
    vt[4]  = '{32'h471C4000, 32'h7FFFFFFF, 4'b0010, 2};
    vt[5]  = '{32'hC7000000, 32'h80000000, 4'b0000, 2};
    vt[6]  = '{32'hFF800000, 32'h80000000, 4'b0100, 2};
    vt[7]  = '{32'h7FC00000, 32'h00000000, 4'b1000, 2};
    vt[8]  = '{32'h00000000, 32'h00000000, 4'b0000, 2};
    vt[9]  = '{32'h00000001, 32'h00000000, 4'b0001, 2};
    vt[10] = '{32'h7F800000, 32'h7FFFFFFF, 4'b0100, 2};
    vt[11] = '{32'h43000000, 32'h00800000, 4'b0000, 2};
    vt[12] = '{32'h46FFFE00, 32'h7FFF0000, 4'b0000, 9};
    vt[13] = '{32'hC7000001, 32'h80000000, 4'b0010, 2};
    vt[14] = '{32'h37800000, 32'h00000001, 4'b0000, 25};
    vt[15] = '{32'h37000000, 32'h00000000, 4'b0001, 26};
    vt[16] = '{32'h36800000, 32'h00000000, 4'b0001, 2};

    #12;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'h0);
    check("rst_out_flags", {28'b0, out_flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vt[i].din, got_d, got_f, got_lat, busy_ok);
      check($sformatf("vec%0d_data", i),  got_d,            vt[i].exp_d);
      check($sformatf("vec%0d_flags", i), {28'b0, got_f},   {28'b0, vt[i].exp_f});
      check($sformatf("vec%0d_lat", i),   32'(got_lat),     32'(vt[i].exp_lat));
      check($sformatf("vec%0d_busy", i),  {31'b0, busy_ok}, 32'd1);
      check($sformatf("vec%0d_drop", i),  {30'b0, out_valid, in_ready}, 32'd1);
    end

    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(105, 146));
      model(x, exp_d, exp_f, exp_lat);
      run_op(x, got_d, got_f, got_lat, busy_ok);
      check($sformatf("rnd%h_data", x),  got_d,          exp_d);
      check($sformatf("rnd%h_flags", x), {28'b0, got_f}, {28'b0, exp_f});
      check($sformatf("rnd%h_lat", x),   32'(got_lat),   32'(exp_lat));
    end

    // Backpressure: 5 cycles of out_ready=0 in DONE, then a new operand offered on the handshake edge.
    @(negedge clk);
    in_data   = 32'h40980000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 64) begin
      @(negedge clk);
      in_data = $urandom;
      guard++;
    end
    check("bp_reach_done", {31'b0, out_valid}, 32'd1);
    d0 = out_data;
    f0 = out_flags;
    check("bp_data", d0, 32'h0004C000);
    stable_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || in_ready || out_data !== d0 || out_flags !== f0) stable_ok = 1'b0;
      if (k < 4) @(negedge clk);
    end
    check("bp_stable", {31'b0, stable_ok}, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hC0080000;
    @(posedge clk);
    #1;
    check("bp_hs_idle", {30'b0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_next_accept", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("bp_next_data", out_data, 32'hFFFDE000);
    @(posedge clk);
    #1;

    // Reset while in SHIFT discards the operand.
    @(negedge clk);
    in_data  = 32'h41180000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, in_ready},  32'd1);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_data",  out_data,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet_ok = 1'b0;
    end
    check("mid_rst_quiet", {31'b0, quiet_ok}, 32'd1);
    run_op(32'h41180000, got_d, got_f, got_lat, busy_ok);
    check("post_rst_data",  got_d,          32'h00098000);
    check("post_rst_flags", {28'b0, got_f}, 32'h0);
    check("post_rst_lat",   32'(got_lat),   32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
